hx8352_init_seq: RTL and testbench
==================================

HX8352_INIT_SEQ -- requirements
Module: hx8352_init_seq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter WR_LOW_CYC, default 2, number of cycles lcd_wr_n is held low per bus write (minimum 1).
REQ-003 SHALL have parameter MS_TICKS, default CLK_HZ/1000, number of clocks per 1 ms delay unit.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  one-cycle pulse that begins the sequence at ROM address 0.
REQ-007 rom_addr  out  8  command ROM address.
REQ-008 rom_data  in  16  ROM word {cmd[15:8], val[7:0]}, valid 1 cycle after rom_addr changes (registered ROM).
REQ-009 lcd_cs_n  out  1  panel chip select, active-low.
REQ-010 lcd_rs  out  1  0 = index write, 1 = parameter write.
REQ-011 lcd_wr_n  out  1  write strobe, active-low; the panel latches on the rising edge.
REQ-012 lcd_rd_n  out  1  read strobe; held at 1 at all times.
REQ-013 lcd_db  out  16  bus data; bits [15:8] are always 0.
REQ-014 busy  out  1  high from the cycle after an accepted start until done rises.
REQ-015 done  out  1  sticky high after the terminator is executed; cleared by start or rst.

Function
REQ-016 States SHALL be IDLE, FETCH, DECODE, IDX_SETUP, IDX_LOW, IDX_HOLD, DAT_SETUP, DAT_LOW, DAT_HOLD, DELAY, FINISH.
REQ-017 In IDLE or FINISH, start SHALL set rom_addr=0, clear done, and enter FETCH; start in any other state SHALL be ignored.
REQ-018 FETCH SHALL last exactly 1 cycle, covering ROM latency; DECODE SHALL register rom_data.
REQ-019 DECODE: cmd=8'hFF SHALL go to FINISH; cmd=8'hFE SHALL go to DELAY; any other cmd SHALL go to IDX_SETUP.
REQ-020 IDX_SETUP: lcd_cs_n=0, lcd_rs=0, lcd_db={8'h00,cmd}, lcd_wr_n=1 for 1 cycle; IDX_LOW: lcd_wr_n=0 for WR_LOW_CYC cycles; IDX_HOLD: lcd_wr_n=1 with data and rs unchanged for 1 cycle.
REQ-021 DAT_SETUP/DAT_LOW/DAT_HOLD SHALL repeat the REQ-020 timing with lcd_rs=1 and lcd_db={8'h00,val}.
REQ-022 After DAT_HOLD, lcd_cs_n SHALL return to 1, rom_addr SHALL increment by 1, and the state SHALL go to FETCH.
REQ-023 One register write SHALL take 2*(WR_LOW_CYC+2) cycles from entering IDX_SETUP to leaving DAT_HOLD, which is 8 cycles at the default.
REQ-024 DELAY SHALL wait val*MS_TICKS cycles using a 32-bit counter, then increment rom_addr and go to FETCH; val=0 SHALL advance after 1 cycle.
REQ-025 During DELAY, lcd_cs_n and lcd_wr_n SHALL be 1 and the bus SHALL not toggle.
REQ-026 In FINISH: done=1, busy=0, lcd_cs_n=1; the state SHALL remain FINISH until start.
REQ-027 Wrap guard: if rom_addr=8'hFF and the word there is not a terminator, the block SHALL execute that word and then enter FINISH instead of wrapping to 0.
REQ-028 Outputs SHALL be registered; no lcd_* output SHALL glitch combinationally.

Reset
REQ-029 When rst is asserted, the block SHALL immediately enter IDLE with rom_addr=0, lcd_cs_n=1, lcd_rs=1, lcd_wr_n=1, lcd_rd_n=1, lcd_db=0, busy=0, done=0, and the delay counter at 0.
REQ-030 Reset asserted mid-write or mid-delay SHALL abort the sequence with no further strobe; a new start is required after reset is released.

Structure
REQ-031 A shared package SHALL hold CMD_DELAY=8'hFE, CMD_DONE=8'hFF, and the state encoding.
REQ-032 The bus write timing (setup/low/hold) SHALL be a sub-module hx8352_bus_wr, with inputs go, rs, and byte, and outputs ack and the lcd_* pins; the sequencer SHALL instantiate it twice per entry or reuse one instance.

Verification
REQ-033 ROM of {8'h83,8'h02},{8'hFF,8'h00}, start pulse -> exactly two wr_n rising edges (rs=0/db=0x0083, then rs=1/db=0x0002), then done=1 and busy=0.
REQ-034 Entry {8'hFE,8'd3} with MS_TICKS=10 -> no strobes for 30 cycles (+/-1), then fetch of the next address.
REQ-035 Entry {8'hFE,8'h00} -> sequence advances after 1 delay cycle with no strobe.
REQ-036 rst asserted during DAT_LOW -> next cycle lcd_wr_n=1, lcd_cs_n=1, busy=0; no further writes until a new start.
REQ-037 start pulse while busy -> ignored, rom_addr sequence unchanged; start after done -> done clears and rom_addr restarts at 0.
REQ-038 ROM with no terminator -> 256 entries executed, FINISH entered, rom_addr never returns to 0.

Source files
------------

// File: rtl/hx8352_init_seq_pkg.sv
// -----------------------------------------------------------------------------
// hx8352_init_seq_pkg
// Shared definitions for the HX8352 panel init sequencer:
//   CMD_DELAY / CMD_DONE  - reserved command codes in the init ROM
//   seq_state_t           - sequencer state encoding
//   wr_phase_t            - bus-write engine phase encoding
// -----------------------------------------------------------------------------
package hx8352_init_seq_pkg;

    localparam logic [7:0] CMD_DELAY = 8'hFE;
    localparam logic [7:0] CMD_DONE  = 8'hFF;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        IDX_SETUP,
        IDX_LOW,
        IDX_HOLD,
        DAT_SETUP,
        DAT_LOW,
        DAT_HOLD,
        DELAY,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_SETUP,
        WR_LOW,
        WR_HOLD
    } wr_phase_t;

endpackage

// File: rtl/hx8352_bus_wr.sv
// -----------------------------------------------------------------------------
// hx8352_bus_wr
// 8080-style write engine: setup (1 cycle), wr_n low (WR_LOW_CYC cycles),
// hold (1 cycle). A go seen during hold chains the next write immediately with
// chip select kept low; otherwise chip select is released after hold.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_go          - start a write (sampled while idle or in hold)
//   i_rs, i_byte  - register-select level and low data byte for the write
//   o_ack         - high in the last wr_n-low cycle; hold follows next cycle
//   o_lcd_*       - registered panel pins (rd_n tied high, db[15:8] zero)
// -----------------------------------------------------------------------------
module hx8352_bus_wr
    import hx8352_init_seq_pkg::*;
#(
    parameter int WR_LOW_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_go,
    input  logic        i_rs,
    input  logic [7:0]  i_byte,
    output logic        o_ack,
    output logic        o_lcd_cs_n,
    output logic        o_lcd_rs,
    output logic        o_lcd_wr_n,
    output logic        o_lcd_rd_n,
    output logic [15:0] o_lcd_db
);

    localparam logic [15:0] LOW_LAST = 16'(WR_LOW_CYC - 1);

    wr_phase_t   r_phase;
    logic [15:0] r_low_cnt;
    logic        r_cs_n;
    logic        r_rs;
    logic        r_wr_n;
    logic [7:0]  r_db;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= WR_IDLE;
            r_low_cnt <= '0;
            r_cs_n    <= 1'b1;
            r_rs      <= 1'b1;
            r_wr_n    <= 1'b1;
            r_db      <= '0;
        end else begin
            case (r_phase)
                WR_IDLE: begin
                    if (i_go) begin
                        r_phase <= WR_SETUP;
                        r_cs_n  <= 1'b0;
                        r_rs    <= i_rs;
                        r_db    <= i_byte;
                        r_wr_n  <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    r_phase   <= WR_LOW;
                    r_wr_n    <= 1'b0;
                    r_low_cnt <= '0;
                end
                WR_LOW: begin
                    if (r_low_cnt == LOW_LAST) begin
                        r_phase <= WR_HOLD;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_low_cnt <= r_low_cnt + 16'd1;
                    end
                end
                WR_HOLD: begin
                    // Chaining keeps cs_n low so index and parameter form one transaction.
                    if (i_go) begin
                        r_phase <= WR_SETUP;
                        r_rs    <= i_rs;
                        r_db    <= i_byte;
                    end else begin
                        r_phase <= WR_IDLE;
                        r_cs_n  <= 1'b1;
                    end
                end
                default: r_phase <= WR_IDLE;
            endcase
        end
    end

    assign o_ack      = (r_phase == WR_LOW) && (r_low_cnt == LOW_LAST);
    assign o_lcd_cs_n = r_cs_n;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_wr_n = r_wr_n;
    assign o_lcd_rd_n = 1'b1;
    assign o_lcd_db   = {8'h00, r_db};

endmodule

// File: rtl/hx8352_init_seq.sv
// -----------------------------------------------------------------------------
// hx8352_init_seq
// Walks a registered command ROM of {cmd, val} words and replays it onto an
// HX8352 8080-style bus: ordinary words become an index write followed by a
// parameter write, CMD_DELAY waits val milliseconds, CMD_DONE ends the run.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - one-cycle pulse, accepted only in IDLE or FINISH
//   rom_addr   - ROM address; rom_data valid one cycle later
//   rom_data   - {cmd[15:8], val[7:0]}
//   lcd_*      - registered panel pins
//   busy, done - sequence running / sequence completed (sticky)
// -----------------------------------------------------------------------------
module hx8352_init_seq
    import hx8352_init_seq_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int WR_LOW_CYC = 2,
    parameter int MS_TICKS   = CLK_HZ / 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_db,
    output logic        busy,
    output logic        done
);

    seq_state_t  r_state;
    logic [7:0]  r_rom_addr;
    logic [7:0]  r_val;
    logic [31:0] r_dly_cnt;
    logic [31:0] r_dly_tgt;
    logic        r_busy;
    logic        r_done;

    logic        w_go;
    logic        w_rs;
    logic [7:0]  w_byte;
    logic        w_ack;
    logic [7:0]  w_cmd;

    assign w_cmd = rom_data[15:8];

    // The index write is launched from DECODE so IDX_SETUP lines up with the
    // engine's setup cycle; the parameter write is chained from IDX_HOLD.
    always_comb begin
        w_go   = 1'b0;
        w_rs   = 1'b0;
        w_byte = w_cmd;
        if (r_state == DECODE && w_cmd != CMD_DONE && w_cmd != CMD_DELAY) begin
            w_go = 1'b1;
        end else if (r_state == IDX_HOLD) begin
            w_go   = 1'b1;
            w_rs   = 1'b1;
            w_byte = r_val;
        end
    end

    hx8352_bus_wr #(
        .WR_LOW_CYC (WR_LOW_CYC)
    ) u_bus_wr (
        .clk        (clk),
        .rst        (rst),
        .i_go       (w_go),
        .i_rs       (w_rs),
        .i_byte     (w_byte),
        .o_ack      (w_ack),
        .o_lcd_cs_n (lcd_cs_n),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_wr_n (lcd_wr_n),
        .o_lcd_rd_n (lcd_rd_n),
        .o_lcd_db   (lcd_db)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rom_addr <= '0;
            r_val      <= '0;
            r_dly_cnt  <= '0;
            r_dly_tgt  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (start) begin
                        r_rom_addr <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: r_state <= DECODE;
                DECODE: begin
                    r_val <= rom_data[7:0];
                    if (w_cmd == CMD_DONE) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_cmd == CMD_DELAY) begin
                        r_dly_tgt <= 32'(rom_data[7:0]) * 32'(MS_TICKS);
                        r_dly_cnt <= '0;
                        r_state   <= DELAY;
                    end else begin
                        r_state <= IDX_SETUP;
                    end
                end
                IDX_SETUP: r_state <= IDX_LOW;
                IDX_LOW:   if (w_ack) r_state <= IDX_HOLD;
                IDX_HOLD:  r_state <= DAT_SETUP;
                DAT_SETUP: r_state <= DAT_LOW;
                DAT_LOW:   if (w_ack) r_state <= DAT_HOLD;
                DAT_HOLD, DELAY: begin
                    // A zero target still spends one cycle in DELAY.
                    if (r_state == DELAY && (r_dly_cnt + 32'd1) < r_dly_tgt) begin
                        r_dly_cnt <= r_dly_cnt + 32'd1;
                    end else begin
                        r_dly_cnt <= '0;
                        // Address 0xFF is the last entry; never wrap back to 0.
                        if (r_rom_addr == 8'hFF) begin
                            r_state <= FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_rom_addr <= r_rom_addr + 8'd1;
                            r_state    <= FETCH;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rom_addr = r_rom_addr;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_hx8352_init_seq.sv
module tb_hx8352_init_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_db;
    logic        busy, done;

    logic [15:0] rom [256];

    int n_checks = 0;
    int n_errors = 0;

    hx8352_init_seq #(
        .CLK_HZ     (50_000_000),
        .WR_LOW_CYC (2),
        .MS_TICKS   (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .lcd_cs_n (lcd_cs_n),
        .lcd_rs   (lcd_rs),
        .lcd_wr_n (lcd_wr_n),
        .lcd_rd_n (lcd_rd_n),
        .lcd_db   (lcd_db),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Registered ROM model
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Bus monitor, sampled on the falling edge
    logic        mon_clr = 1'b0;
    int          n_wr_rise, n_wr_low, n_cs_low, n_db_chg, n_addr0, n_back0;
    logic [15:0] wr_db [8];
    logic        wr_rs [8];
    logic [15:0] last_db;
    logic        prev_wr_n = 1'b1;
    logic [15:0] prev_db = 16'h0;
    logic [7:0]  prev_addr = 8'h0;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_wr_rise = 0; n_wr_low = 0; n_cs_low = 0;
            n_db_chg = 0; n_addr0 = 0; n_back0 = 0;
            last_db = 16'h0;
        end else begin
            if (!prev_wr_n && lcd_wr_n) begin
                if (n_wr_rise < 8) begin
                    wr_db[n_wr_rise] = lcd_db;
                    wr_rs[n_wr_rise] = lcd_rs;
                end
                last_db = lcd_db;
                n_wr_rise++;
            end
            if (!lcd_wr_n) n_wr_low++;
            if (!lcd_cs_n) n_cs_low++;
            if (lcd_db !== prev_db) n_db_chg++;
            if (busy && rom_addr == 8'h00) n_addr0++;
            if (busy && prev_addr != 8'h00 && rom_addr == 8'h00) n_back0++;
        end
        prev_wr_n = lcd_wr_n;
        prev_db   = lcd_db;
        prev_addr = rom_addr;
    end

    task automatic clear_mon();
        @(posedge clk) #1 mon_clr = 1'b1;
        @(posedge clk) #1 mon_clr = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk) #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (rom_addr !== 8'h00) begin n_errors++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
        n_checks++; if (lcd_cs_n !== 1'b1) begin n_errors++; $display("FAIL reset_cs_n: got %b want 1", lcd_cs_n); end
        n_checks++; if (lcd_rs !== 1'b1) begin n_errors++; $display("FAIL reset_rs: got %b want 1", lcd_rs); end
        n_checks++; if (lcd_wr_n !== 1'b1) begin n_errors++; $display("FAIL reset_wr_n: got %b want 1", lcd_wr_n); end
        n_checks++; if (lcd_rd_n !== 1'b1) begin n_errors++; $display("FAIL reset_rd_n: got %b want 1", lcd_rd_n); end
        n_checks++; if (lcd_db !== 16'h0000) begin n_errors++; $display("FAIL reset_db: got %h want 0000", lcd_db); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic test_basic_write();
        bit to;
        fill_rom(16'hFF00);
        rom[0] = 16'h8302;
        rom[1] = 16'hFF00;
        clear_mon();
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy_rise: got %b want 1", busy); end
        wait_done(200, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL basic_timeout: done got 0 want 1"); end
        n_checks++; if (n_wr_rise != 2) begin n_errors++; $display("FAIL basic_strobes: got %0d want 2", n_wr_rise); end
        n_checks++; if (wr_rs[0] !== 1'b0 || wr_db[0] !== 16'h0083) begin n_errors++; $display("FAIL basic_index: got rs=%b db=%h want rs=0 db=0083", wr_rs[0], wr_db[0]); end
        n_checks++; if (wr_rs[1] !== 1'b1 || wr_db[1] !== 16'h0002) begin n_errors++; $display("FAIL basic_param: got rs=%b db=%h want rs=1 db=0002", wr_rs[1], wr_db[1]); end
        n_checks++; if (n_wr_low != 4) begin n_errors++; $display("FAIL basic_wr_low_cycles: got %0d want 4", n_wr_low); end
        n_checks++; if (n_cs_low != 8) begin n_errors++; $display("FAIL basic_cs_low_cycles: got %0d want 8", n_cs_low); end
        n_checks++; if (busy !== 1'b0 || lcd_cs_n !== 1'b1) begin n_errors++; $display("FAIL basic_end: got busy=%b cs_n=%b want busy=0 cs_n=1", busy, lcd_cs_n); end
        n_checks++; if (rom_addr !== 8'h01) begin n_errors++; $display("FAIL basic_end_addr: got %h want 01", rom_addr); end
    endtask

    task automatic test_delay(input logic [7:0] val, input int exp_addr0);
        bit to;
        fill_rom(16'hFF00);
        rom[0] = {8'hFE, val};
        clear_mon();
        pulse_start();
        wait_done(500, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL delay%0d_timeout: done got 0 want 1", val); end
        n_checks++; if (n_addr0 != exp_addr0) begin n_errors++; $display("FAIL delay%0d_cycles_at_addr0: got %0d want %0d", val, n_addr0, exp_addr0); end
        n_checks++; if (n_wr_rise != 0 || n_cs_low != 0) begin n_errors++; $display("FAIL delay%0d_no_strobe: got wr=%0d cs_low=%0d want 0 0", val, n_wr_rise, n_cs_low); end
        n_checks++; if (n_db_chg != 0) begin n_errors++; $display("FAIL delay%0d_bus_quiet: got %0d changes want 0", val, n_db_chg); end
        n_checks++; if (rom_addr !== 8'h01) begin n_errors++; $display("FAIL delay%0d_next_addr: got %h want 01", val, rom_addr); end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        fill_rom(16'hFF00);
        rom[0] = 16'h8302;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk) #1;
            if (lcd_rs && !lcd_wr_n && !lcd_cs_n) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL rstmid_reach_dat_low: got 0 want 1"); end
        rst = 1'b1;
        @(posedge clk) #1;
        n_checks++; if (lcd_wr_n !== 1'b1 || lcd_cs_n !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_abort: got wr_n=%b cs_n=%b busy=%b want 1 1 0", lcd_wr_n, lcd_cs_n, busy); end
        rst = 1'b0;
        clear_mon();
        repeat (30) @(posedge clk);
        #1;
        n_checks++; if (n_wr_rise != 0 || n_cs_low != 0) begin n_errors++; $display("FAIL rstmid_quiet: got wr=%0d cs_low=%0d want 0 0", n_wr_rise, n_cs_low); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 8'h00) begin n_errors++; $display("FAIL rstmid_idle: got busy=%b done=%b addr=%h want 0 0 00", busy, done, rom_addr); end
    endtask

    task automatic test_start_while_busy();
        bit to;
        fill_rom(16'hFF00);
        rom[0] = 16'h8302;
        rom[1] = 16'h8405;
        pulse_start();
        clear_mon();
        repeat (3) @(posedge clk);
        pulse_start();
        wait_done(300, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL busy_timeout: done got 0 want 1"); end
        n_checks++; if (n_wr_rise != 4) begin n_errors++; $display("FAIL busy_strobes: got %0d want 4", n_wr_rise); end
        n_checks++; if (wr_db[0] !== 16'h0083 || wr_db[1] !== 16'h0002 || wr_db[2] !== 16'h0084 || wr_db[3] !== 16'h0005) begin n_errors++; $display("FAIL busy_data: got %h %h %h %h want 0083 0002 0084 0005", wr_db[0], wr_db[1], wr_db[2], wr_db[3]); end
        n_checks++; if (wr_rs[2] !== 1'b0 || wr_rs[3] !== 1'b1) begin n_errors++; $display("FAIL busy_rs: got %b %b want 0 1", wr_rs[2], wr_rs[3]); end
        n_checks++; if (n_back0 != 0 || rom_addr !== 8'h02) begin n_errors++; $display("FAIL busy_addr: got back0=%0d addr=%h want 0 02", n_back0, rom_addr); end
        pulse_start();
        n_checks++; if (done !== 1'b0 || busy !== 1'b1 || rom_addr !== 8'h00) begin n_errors++; $display("FAIL restart: got done=%b busy=%b addr=%h want 0 1 00", done, busy, rom_addr); end
        wait_done(300, to);
        n_checks++; if (to || n_wr_rise != 8) begin n_errors++; $display("FAIL restart_run: got timeout=%b strobes=%0d want 0 8", to, n_wr_rise); end
    endtask

    task automatic test_wrap();
        bit to;
        for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
        pulse_start();
        clear_mon();
        wait_done(5000, to);
        n_checks++; if (to) begin n_errors++; $display("FAIL wrap_timeout: done got 0 want 1"); end
        n_checks++; if (n_wr_rise != 512) begin n_errors++; $display("FAIL wrap_strobes: got %0d want 512", n_wr_rise); end
        n_checks++; if (wr_db[0] !== 16'h0010 || wr_db[1] !== 16'h0000 || wr_db[3] !== 16'h0001) begin n_errors++; $display("FAIL wrap_first: got %h %h %h want 0010 0000 0001", wr_db[0], wr_db[1], wr_db[3]); end
        n_checks++; if (last_db !== 16'h00FF) begin n_errors++; $display("FAIL wrap_last: got %h want 00ff", last_db); end
        n_checks++; if (n_back0 != 0 || rom_addr !== 8'hFF) begin n_errors++; $display("FAIL wrap_no_wrap: got back0=%0d addr=%h want 0 ff", n_back0, rom_addr); end
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'hFF) begin n_errors++; $display("FAIL wrap_stay: got done=%b busy=%b addr=%h want 1 0 ff", done, busy, rom_addr); end
    endtask

    initial begin
        fill_rom(16'hFF00);
        test_reset();
        test_basic_write();
        test_delay(8'd3, 32);
        test_delay(8'd0, 3);
        test_reset_mid_write();
        test_start_while_busy();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
